// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory responder
package imem_pkg;

  // Responder FSM encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int          DEFAULT_MEM_WORDS = 4096;
  localparam int          DEFAULT_LATENCY   = 3;
  // RV32I NOP (addi x0, x0, 0) so a stray fetch executes harmlessly
  localparam logic [31:0] DEFAULT_ERR_WORD  = 32'h0000_0013;
  localparam int          WORD_ADDR_W       = 30;

endpackage

// File: rtl/imem_store.sv
// rtl/imem_store.sv - word array with registered read and read-before-write behaviour
module imem_store
  import imem_pkg::*;
#(
  parameter int WORDS = DEFAULT_MEM_WORDS,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data
);

  // Contents are deliberately not reset so an image survives a responder reset
  logic [31:0] mem [WORDS];

  // Write port; a same-edge read still sees the previous word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read that holds its value until the next enabled read
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - icache refill responder with programmable latency and load port
module imem_responder
  import imem_pkg::*;
#(
  parameter int          MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int          LATENCY   = DEFAULT_LATENCY,
  parameter logic [31:0] ERR_WORD  = DEFAULT_ERR_WORD
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_req_valid,
  input  logic [31:0] mem_req_addr,
  output logic        mem_req_ready,
  output logic [31:0] mem_req_rdata,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        err,
  output logic [31:0] resp_count
);

  localparam int         AW     = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t                 state_q;
  logic [WORD_ADDR_W-1:0] addr_q;
  logic [3:0]             cnt_q;
  logic                   oor_q;
  logic [31:0]            store_rdata;
  logic                   fire;
  logic                   req_in_range;
  logic                   ld_in_range;
  logic [WORD_ADDR_W-1:0] ld_word;
  logic                   unused_byte_bits;

  assign unused_byte_bits = ^{mem_req_addr[1:0], ld_addr[1:0]};

  assign ld_word      = ld_addr[31:2];
  assign req_in_range = (addr_q >> AW) == '0;
  assign ld_in_range  = (ld_word >> AW) == '0;

  // The single cycle in which the response word is fetched and ready is raised
  assign fire = (state_q == WAIT) && mem_req_valid && (cnt_q == 4'd0);

  imem_store #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_store (
    .clk     (clk),
    .resetn  (resetn),
    .rd_en   (fire && req_in_range),
    .rd_addr (addr_q[AW-1:0]),
    .rd_data (store_rdata),
    .wr_en   (ld_valid && ld_in_range),
    .wr_addr (ld_word[AW-1:0]),
    .wr_data (ld_data)
  );

  // Both sources are registers, so the response word is stable for the whole pulse
  // and keeps the last value until the next response
  assign mem_req_rdata = oor_q ? ERR_WORD : store_rdata;

  // Request sequencing: capture, count down, one-cycle pulse, then wait for valid to drop
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      oor_q         <= 1'b0;
      mem_req_ready <= 1'b0;
      err           <= 1'b0;
      resp_count    <= '0;
    end else begin
      mem_req_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_req_valid) begin
            addr_q  <= mem_req_addr[31:2];
            cnt_q   <= LAT_M1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!mem_req_valid) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            oor_q         <= !req_in_range;
            mem_req_ready <= 1'b1;
            state_q       <= RESP;
            if (!req_in_range) begin
              err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          resp_count <= resp_count + 32'd1;
          state_q    <= DRAIN;
        end
        DRAIN: begin
          if (!mem_req_valid) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - randomized self-checking bench for imem_responder
module tb_imem_responder;
  import imem_pkg::*;

  localparam int LAT   = 3;
  localparam int WORDS = 4096;
  localparam int WIN   = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_req_valid = 1'b0;
  logic [31:0] mem_req_addr = '0;
  logic        mem_req_ready;
  logic [31:0] mem_req_rdata;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        err;
  logic [31:0] resp_count;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [WIN];
  logic [31:0] exp_count = '0;
  logic        exp_err = 1'b0;
  logic        prev_ready = 1'b0;

  imem_responder #(
    .MEM_WORDS (WORDS),
    .LATENCY   (LAT),
    .ERR_WORD  (32'h0000_0013)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_req_rdata (mem_req_rdata),
    .ld_valid      (ld_valid),
    .ld_addr       (ld_addr),
    .ld_data       (ld_data),
    .err           (err),
    .resp_count    (resp_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Ready must never be high in two consecutive cycles
  always @(negedge clk) begin
    if (!resetn) begin
      prev_ready = 1'b0;
    end else begin
      check_eq("ready_twice", 32'(prev_ready && mem_req_ready), 32'd0);
      prev_ready = mem_req_ready;
    end
  end

  task automatic do_load(input logic [31:0] idx, input logic [31:0] data);
    ld_valid = 1'b1;
    ld_addr  = {idx[29:0], 2'($urandom)};
    ld_data  = data;
    @(negedge clk);
    ld_valid = 1'b0;
    if (idx < WIN) ref_mem[idx] = data;
  endtask

  // One request; optionally hold valid after the pulse and/or load the same word on the read edge
  task automatic do_read(input logic [31:0] addr, input int hold, input bit collide);
    logic [31:0] idx;
    logic [31:0] exp_data;
    logic [31:0] cdata;
    bit          oor;
    idx      = {2'b00, addr[31:2]};
    oor      = (idx >= WORDS);
    exp_data = oor ? 32'h0000_0013 : ref_mem[idx[5:0]];
    cdata    = $urandom();
    mem_req_valid = 1'b1;
    mem_req_addr  = addr;
    for (int j = 0; j <= LAT; j++) begin
      @(negedge clk);
      ld_valid     = 1'b0;
      mem_req_addr = $urandom();
      check_eq("ready_timing", 32'(mem_req_ready), 32'(j == LAT));
      if (j == LAT) check_eq("rdata", mem_req_rdata, exp_data);
      else if (collide && !oor && j == LAT - 1) begin
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_data  = cdata;
      end
    end
    exp_count = exp_count + 32'd1;
    exp_err   = exp_err | oor;
    if (collide && !oor) ref_mem[idx[5:0]] = cdata;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_no_pulse", 32'(mem_req_ready), 32'd0);
    end
    if (hold > 0) check_eq("state_drain", 32'(dut.state_q), 32'(DRAIN));
    mem_req_valid = 1'b0;
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      check_eq("gap_no_pulse", 32'(mem_req_ready), 32'd0);
    end
    check_eq("state_idle", 32'(dut.state_q), 32'(IDLE));
    check_eq("resp_count", resp_count, exp_count);
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("rdata_hold", mem_req_rdata, exp_data);
  endtask

  // Valid drops after the sample following edge E<drop_j>, i.e. while still in WAIT
  task automatic do_abort(input int drop_j);
    mem_req_valid = 1'b1;
    mem_req_addr  = {24'd0, 6'($urandom), 2'b00};
    for (int j = 0; j <= drop_j; j++) begin
      @(negedge clk);
      check_eq("abort_no_pulse", 32'(mem_req_ready), 32'd0);
    end
    mem_req_valid = 1'b0;
    for (int j = 0; j < LAT + 2; j++) begin
      @(negedge clk);
      check_eq("abort_no_pulse", 32'(mem_req_ready), 32'd0);
    end
    check_eq("abort_idle", 32'(dut.state_q), 32'(IDLE));
    check_eq("abort_count", resp_count, exp_count);
  endtask

  // Start a request on word 5 and pull reset between edges after E<stop_j>
  task automatic do_reset_mid(input int stop_j);
    mem_req_valid = 1'b1;
    mem_req_addr  = 32'h14;
    for (int j = 0; j <= stop_j; j++) begin
      @(negedge clk);
      check_eq("pre_rst_ready", 32'(mem_req_ready), 32'(j == LAT));
    end
    #2 resetn = 1'b0;
    #1;
    check_eq("rst_ready", 32'(mem_req_ready), 32'd0);
    check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("rst_rdata", mem_req_rdata, 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_count", resp_count, 32'd0);
    mem_req_valid = 1'b0;
    @(negedge clk);
    resetn    = 1'b1;
    exp_count = '0;
    exp_err   = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_oor_addr();
    logic [31:0] a;
    a = $urandom();
    if (a[31:14] == '0) a[31] = 1'b1;
    return a;
  endfunction

  initial begin
    int op;
    repeat (2) @(negedge clk);
    check_eq("reset_ready", 32'(mem_req_ready), 32'd0);
    check_eq("reset_rdata", mem_req_rdata, 32'd0);
    check_eq("reset_err", 32'(err), 32'd0);
    check_eq("reset_count", resp_count, 32'd0);
    check_eq("reset_state", 32'(dut.state_q), 32'(IDLE));
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < WIN; i++) do_load(32'(i), $urandom());
    do_load(32'd5, 32'hDEAD_BEEF);

    do_read(32'h14, 0, 1'b0);
    for (int i = 0; i < 4; i++) do_read(32'h40 + 32'(4 * i), 0, 1'b0);
    do_read(32'h48, 20, 1'b0);
    do_abort(0);
    do_abort(LAT - 1);

    // Out-of-range loads must be dropped, not aliased onto low words
    for (int i = 0; i < 4; i++) do_load(32'(WORDS + i), $urandom());
    check_eq("oor_load_no_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) do_read(32'(4 * i), 0, 1'b0);

    do_read(32'h0001_0000, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op < 2) do_load(32'($urandom_range(0, WIN - 1)), $urandom());
      else if (op == 2) do_load(32'(WORDS) + 32'($urandom_range(0, 2 * WIN)), $urandom());
      else if (op == 3) do_abort($urandom_range(0, LAT - 1));
      else if (op == 4) do_read(rand_oor_addr(), $urandom_range(0, 3), 1'b0);
      else do_read({24'd0, 6'($urandom_range(0, WIN - 1)), 2'($urandom)},
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
    end
    check_eq("err_sticky", 32'(err), 32'd1);

    do_reset_mid(1);
    do_read(32'h14, 0, 1'b0);
    do_reset_mid(LAT);
    for (int i = 0; i < 8; i++) do_read({24'd0, 6'($urandom_range(0, WIN - 1)), 2'b00}, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
